poly_op_sched: RTL and testbench

Command-driven sequencer for the polynomial arithmetic unit. It accepts operation commands (NTT, INVNTT, MULT, ADDSUB) through a valid/ready port and buffers them in a 2-entry FIFO. For each command it drives `mode` and the 8-bit `clk_counter` into `addr_gen`, generates read/write enables for the coefficient RAM with a fixed pipeline drain, and reports completion. It sits between the top-level host/control logic and `addr_gen` plus the butterfly datapath.

---
 rtl/poly_op_sched.sv | 162 ++++++++++++++++
 tb/tb_poly_op_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_op_sched.sv
// Command sequencer for the polynomial arithmetic unit: queues NTT/INVNTT/MULT/ADDSUB
// commands and drives addr_gen (mode, clk_counter) plus coefficient RAM enables.
module poly_op_sched #(
    parameter int NTT_LEN    = 224,
    parameter int INTT_LEN   = 224,
    parameter int MULT_LEN   = 64,
    parameter int ADDSUB_LEN = 32,
    parameter int PIPE_LAT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    output logic [1:0] mode,
    output logic [7:0] clk_counter,
    output logic       rd_en,
    output logic       wr_en,
    output logic       busy,
    output logic       done,
    output logic [1:0] done_mode
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [1:0]          r_fifo [2];
    logic                r_wr_ptr, r_rd_ptr;
    logic [1:0]          r_count;
    logic [7:0]          r_counter, w_counter_next;
    logic [1:0]          r_mode, w_mode_next;
    logic [3:0]          r_drain, w_drain_next;
    logic [8:0]          w_last;
    logic [PIPE_LAT-1:0] r_wr_sr;
    logic                w_push, w_pop, w_full, w_empty, w_rd_en;

    // Pop decisions use the occupancy before this edge's push, so there is no bypass.
    assign w_full    = (r_count == 2'd2);
    assign w_empty   = (r_count == 2'd0);
    assign cmd_ready = rst & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= cmd_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // 9-bit terminal count so a 256-cycle operation ends at 255 without wrapping.
    always_comb begin
        case (r_mode)
            2'd0:    w_last = 9'(NTT_LEN - 1);
            2'd1:    w_last = 9'(INTT_LEN - 1);
            2'd2:    w_last = 9'(MULT_LEN - 1);
            default: w_last = 9'(ADDSUB_LEN - 1);
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        w_mode_next    = r_mode;
        w_drain_next   = r_drain;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_counter_next = 8'd0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_mode_next  = r_fifo[r_rd_ptr];
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if ({1'b0, r_counter} == w_last) begin
                    w_drain_next = 4'd0;
                    w_state_next = S_DRAIN;
                end else begin
                    w_counter_next = r_counter + 8'd1;
                end
            end
            S_DRAIN: begin
                if (r_drain == 4'(PIPE_LAT - 1)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_drain_next = r_drain + 4'd1;
                end
            end
            default: begin
                w_counter_next = 8'd0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_mode_next  = r_fifo[r_rd_ptr];
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_counter <= 8'd0;
            r_mode    <= 2'd0;
            r_drain   <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_counter <= w_counter_next;
            r_mode    <= w_mode_next;
            r_drain   <= w_drain_next;
        end
    end

    assign w_rd_en = (r_state == S_RUN);

    // Write enable trails read enable by the butterfly pipeline latency.
    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_wr_sr
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!rst) r_wr_sr[gi] <= 1'b0;
                else      r_wr_sr[gi] <= w_rd_en;
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (!rst) r_wr_sr[gi] <= 1'b0;
                else      r_wr_sr[gi] <= r_wr_sr[gi-1];
            end
        end
    end

    assign rd_en       = w_rd_en;
    assign wr_en       = r_wr_sr[PIPE_LAT-1];
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign done_mode   = (r_state == S_DONE) ? r_mode : 2'd0;
    assign mode        = r_mode;
    assign clk_counter = r_counter;

endmodule

// File: tb/tb_poly_op_sched.sv
// Scoreboard bench for poly_op_sched: two instances (default, and PIPE_LAT=1 with MULT_LEN=256)
// checked each cycle against a per-operation timeline derived from the command queue.
module tb_poly_op_sched;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [NI-1:0] cmd_valid = '0;
    logic [NI-1:0] cmd_ready, rd_en, wr_en, busy, done;
    logic [1:0]    cmd_mode    [NI];
    logic [1:0]    mode        [NI];
    logic [1:0]    done_mode   [NI];
    logic [7:0]    clk_counter [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        poly_op_sched #(
            .MULT_LEN ((gi == 0) ? 64 : 256),
            .PIPE_LAT ((gi == 0) ? 4 : 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .cmd_valid   (cmd_valid[gi]),
            .cmd_mode    (cmd_mode[gi]),
            .cmd_ready   (cmd_ready[gi]),
            .mode        (mode[gi]),
            .clk_counter (clk_counter[gi]),
            .rd_en       (rd_en[gi]),
            .wr_en       (wr_en[gi]),
            .busy        (busy[gi]),
            .done        (done[gi]),
            .done_mode   (done_mode[gi])
        );
    end

    typedef struct {
        logic [1:0] m;
        int         push_edge;
    } exp_t;

    exp_t exp_q [NI][$];

    function automatic int len_of(input int i, input logic [1:0] m);
        case (m)
            2'd0:    return 224;
            2'd1:    return 224;
            2'd2:    return (i == 0) ? 64 : 256;
            default: return 32;
        endcase
    endfunction

    function automatic int pl_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    int   cyc = 0;
    logic rst_edge = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         in_op     [NI];
    int         t_op      [NI];
    logic [1:0] cur_mode  [NI];
    logic [1:0] last_mode [NI];

    // Monitor: an operation that starts in cycle c has rd_en for LEN cycles, wr_en
    // PIPE_LAT later, and done at c+LEN+PIPE_LAT; queued work starts the cycle after
    // its push edge at the earliest.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [16:0] act, expv;
            logic        exp_done;
            int          len, pl, occ, t;
            string       nm;
            pl = pl_of(i);
            exp_done = 1'b0;
            if (!rst_edge) begin
                nm   = "reset_state";
                expv = {4'b0000, 1'b0, 2'd0, 8'd0, 2'd0};
                act  = {rd_en[i], wr_en[i], busy[i], done[i], cmd_ready[i],
                        mode[i], clk_counter[i], done_mode[i]};
                exp_q[i].delete();
                in_op[i]     = 1'b0;
                last_mode[i] = 2'd0;
            end else begin
                if (!in_op[i] && exp_q[i].size() > 0 && exp_q[i][0].push_edge <= cyc - 1) begin
                    in_op[i]    = 1'b1;
                    t_op[i]     = 0;
                    cur_mode[i] = exp_q[i][0].m;
                end
                if (in_op[i]) begin
                    nm       = "op_timeline";
                    len      = len_of(i, cur_mode[i]);
                    t        = t_op[i];
                    exp_done = (t == len + pl);
                    occ      = exp_q[i].size() - 1;
                    expv = {t < len, (t >= pl) && (t < pl + len), 1'b1, exp_done, occ < 2,
                            cur_mode[i], (t < len) ? 8'(t) : 8'(len - 1),
                            exp_done ? cur_mode[i] : 2'd0};
                    if (exp_done) begin
                        void'(exp_q[i].pop_front());
                        in_op[i]     = 1'b0;
                        last_mode[i] = cur_mode[i];
                    end else begin
                        t_op[i] = t + 1;
                    end
                end else begin
                    nm   = "idle_state";
                    occ  = exp_q[i].size();
                    expv = {4'b0000, occ < 2, last_mode[i], 8'd0, 2'd0};
                end
                act = {rd_en[i], wr_en[i], busy[i], done[i], cmd_ready[i],
                       mode[i], clk_counter[i], exp_done ? done_mode[i] : 2'd0};
            end
            n_tests++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL %s inst%0d cycle %0d: got rd/wr/busy/done/rdy/mode/ctr/dmode=%h expected %h",
                         nm, i, cyc, act, expv);
            end
        end
    end

    task automatic send(input int i, input logic [1:0] m);
        int budget = 3000;
        @(negedge clk);
        #2;
        cmd_valid[i] = 1'b1;
        cmd_mode[i]  = m;
        while (!cmd_ready[i]) begin
            if (budget == 0) begin
                $display("FAIL send_timeout inst%0d: cmd_ready stayed 0, required 1", i);
                $fatal(1);
            end
            budget--;
            @(negedge clk);
            #2;
        end
        exp_q[i].push_back('{m, cyc + 1});
        $display("[TB] push inst%0d mode %0d at edge %0d", i, m, cyc + 1);
        @(posedge clk);
        #1;
        cmd_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int budget = 3000;
        do begin
            if (budget == 0) begin
                $display("FAIL idle_timeout inst%0d: queue=%0d busy=%0b, required 0/0",
                         i, exp_q[i].size(), busy[i]);
                $fatal(1);
            end
            budget--;
            @(negedge clk);
            #2;
        end while (exp_q[i].size() != 0 || busy[i]);
    endtask

    task automatic wait_counter(input int i, input logic [7:0] v);
        int budget = 3000;
        do begin
            if (budget == 0) begin
                $display("FAIL counter_timeout inst%0d: clk_counter=%0d, required %0d", i, clk_counter[i], v);
                $fatal(1);
            end
            budget--;
            @(negedge clk);
            #2;
        end while (!(rd_en[i] && clk_counter[i] == v));
    endtask

    initial begin
        cmd_mode[0] = 2'd0;
        cmd_mode[1] = 2'd0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Single NTT.
        send(0, 2'd0);
        wait_idle(0);

        // Back-to-back INVNTT then MULT.
        send(0, 2'd1);
        send(0, 2'd2);
        wait_idle(0);

        // Backpressure: fourth command waits for the DONE-cycle pop.
        send(0, 2'd0);
        send(0, 2'd1);
        send(0, 2'd2);
        send(0, 2'd3);
        wait_idle(0);

        // Reset mid-RUN with a command queued behind it.
        send(0, 2'd0);
        send(0, 2'd3);
        wait_counter(0, 8'd100);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        send(0, 2'd3);
        wait_idle(0);

        // PIPE_LAT=1 ADDSUB and 256-cycle MULT.
        send(1, 2'd3);
        send(1, 2'd2);
        wait_idle(1);

        // Randomized traffic on both instances.
        for (int k = 0; k < 24; k++) begin
            send(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(0);
        wait_idle(1);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
